// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the 2:1 time-division multiplexing layer.
//   DEF_WIDTH     - default data bits per lane
//   DEF_LANES_OUT - default number of output lanes
//   PHASE_EVEN    - phase in which even lanes are emitted and odd lanes captured
//   PHASE_ODD     - phase in which the held odd lanes are emitted
package mux_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES_OUT = 2;
    localparam logic PHASE_EVEN = 1'b0;
    localparam logic PHASE_ODD = 1'b1;
endpackage

// File: rtl/serial_lane.sv
// serial_lane: serialises one even/odd input pair onto a single registered output lane.
//   clk, reset              - clock, async active-high reset
//   adv                     - advance this cycle (enable and not align)
//   phase                   - shared layer phase
//   even_data, even_valid   - input lane 2j
//   odd_data, odd_valid     - input lane 2j+1 (captured into hold at even phase)
//   data_out, valid_out     - registered output lane j
module serial_lane import mux_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             phase,
    input  logic [WIDTH-1:0] even_data,
    input  logic             even_valid,
    input  logic [WIDTH-1:0] odd_data,
    input  logic             odd_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);
    logic [WIDTH-1:0] hold_data_q, hold_data_d, data_q, data_d, sel_data;
    logic             hold_valid_q, hold_valid_d, valid_q, valid_d, sel_valid, cap;
    always_comb begin
        cap = adv && phase == PHASE_EVEN;
        hold_data_d = cap ? odd_data : hold_data_q;
        hold_valid_d = cap ? odd_valid : hold_valid_q;
        sel_data = phase == PHASE_EVEN ? even_data : hold_data_q;
        sel_valid = phase == PHASE_EVEN ? even_valid : hold_valid_q;
        valid_d = adv & sel_valid;
        // An idle cycle either blanks the lane or freezes its last data.
        data_d = adv ? ((ZERO_INVALID && !sel_valid) ? '0 : sel_data)
                     : (ZERO_INVALID ? '0 : data_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data_q <= '0;
            hold_valid_q <= 1'b0;
            data_q <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            data_q <= data_d;
            valid_q <= valid_d;
        end
    end
    assign data_out = data_q;
    assign valid_out = valid_q;
endmodule

// File: rtl/mux_serial_layer.sv
// mux_serial_layer: 2:1 TDM layer folding 2*LANES_OUT input lanes onto LANES_OUT output lanes.
//   clk, reset          - clock, async active-high reset
//   enable              - advance phase and update outputs
//   align               - synchronous realignment to the even phase (overrides enable)
//   data_in, valid_in   - 2*LANES_OUT input lanes and their valids
//   data_out, valid_out - LANES_OUT registered output lanes and their valids
//   phase               - registered current phase
module mux_serial_layer import mux_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES_OUT = DEF_LANES_OUT,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         align,
    input  logic [2*LANES_OUT*WIDTH-1:0] data_in,
    input  logic [2*LANES_OUT-1:0]       valid_in,
    output logic [LANES_OUT*WIDTH-1:0]   data_out,
    output logic [LANES_OUT-1:0]         valid_out,
    output logic                         phase
);
    logic phase_q, phase_d, adv;
    always_comb begin
        adv = enable & ~align;
        phase_d = align ? PHASE_EVEN : (enable ? ~phase_q : phase_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) phase_q <= PHASE_EVEN;
        else phase_q <= phase_d;
    end
    assign phase = phase_q;
    for (genvar j = 0; j < LANES_OUT; j++) begin : g_lane
        serial_lane #(.WIDTH(WIDTH), .ZERO_INVALID(ZERO_INVALID)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .adv       (adv),
            .phase     (phase_q),
            .even_data (data_in[2*j*WIDTH +: WIDTH]),
            .even_valid(valid_in[2*j]),
            .odd_data  (data_in[(2*j+1)*WIDTH +: WIDTH]),
            .odd_valid (valid_in[2*j+1]),
            .data_out  (data_out[j*WIDTH +: WIDTH]),
            .valid_out (valid_out[j])
        );
    end
endmodule

// File: tb/tb_mux_serial_layer.sv
// tb_mux_serial_layer: directed table-driven bench for mux_serial_layer in three configurations.
module tb_mux_serial_layer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        align = 1'b0;
    logic [31:0] din = '0;
    logic [3:0]  vin = '0;
    logic [15:0] d0, d1;
    logic [1:0]  v0, v1;
    logic        p0, p1, p2;
    logic [127:0] din2;
    logic [63:0] d2;
    logic [3:0]  v2;
    int checks = 0;
    int errors = 0;

    localparam logic [63:0] EV2 = 64'h1006_1004_1002_1000;
    localparam logic [63:0] OD2 = 64'h1007_1005_1003_1001;

    always #5 clk = ~clk;

    mux_serial_layer #(.WIDTH(8), .LANES_OUT(2), .ZERO_INVALID(1'b1)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .align(align),
        .data_in(din), .valid_in(vin), .data_out(d0), .valid_out(v0), .phase(p0));
    mux_serial_layer #(.WIDTH(8), .LANES_OUT(2), .ZERO_INVALID(1'b0)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .align(align),
        .data_in(din), .valid_in(vin), .data_out(d1), .valid_out(v1), .phase(p1));
    mux_serial_layer #(.WIDTH(16), .LANES_OUT(4), .ZERO_INVALID(1'b1)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .align(align),
        .data_in(din2), .valid_in(8'hFF), .data_out(d2), .valid_out(v2), .phase(p2));

    typedef struct {
        logic        en;
        logic        al;
        logic [31:0] din;
        logic [3:0]  vin;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  v;
        logic        ph;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [1:0] ev, input logic eph);
        chk({tag, " d0"}, 64'(d0), 64'(e0));
        chk({tag, " v0"}, 64'(v0), 64'(ev));
        chk({tag, " ph0"}, 64'(p0), 64'(eph));
        chk({tag, " d1"}, 64'(d1), 64'(e1));
        chk({tag, " v1"}, 64'(v1), 64'(ev));
        chk({tag, " ph2"}, 64'(p2), 64'(eph));
    endtask

    initial begin
        vec_t tbl[$];
        logic ph_prev;
        logic adv;
        for (int i = 0; i < 8; i++) din2[i*16 +: 16] = 16'h1000 + 16'(i);
        // continuous all-valid stream
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hF, 16'h3311, 16'h3311, 2'b11, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hF, 16'h4422, 16'h4422, 2'b11, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hF, 16'h3311, 16'h3311, 2'b11, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hF, 16'h4422, 16'h4422, 2'b11, 1'b0});
        // lane 1 invalid: blanked only when ZERO_INVALID=1
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hD, 16'h3311, 16'h3311, 2'b11, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hD, 16'h4400, 16'h4422, 2'b10, 1'b0});
        // enable low for 3 cycles after the even capture; odd sample survives
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hF, 16'h3311, 16'h3311, 2'b11, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'hDDCCBBAA, 4'hF, 16'h0000, 16'h3311, 2'b00, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'hDDCCBBAA, 4'hF, 16'h0000, 16'h3311, 2'b00, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'hDDCCBBAA, 4'hF, 16'h0000, 16'h3311, 2'b00, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'hDDCCBBAA, 4'hF, 16'h4422, 16'h4422, 2'b11, 1'b0});
        // align during odd phase drops the pending sample
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hF, 16'h3311, 16'h3311, 2'b11, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 32'h44332211, 4'hF, 16'h0000, 16'h3311, 2'b00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h88776655, 4'hF, 16'h7755, 16'h7755, 2'b11, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h88776655, 4'hF, 16'h8866, 16'h8866, 2'b11, 1'b0});
        // align with enable low at even phase, then at odd phase
        tbl.push_back('{1'b0, 1'b1, 32'h88776655, 4'hF, 16'h0000, 16'h8866, 2'b00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h44332211, 4'hF, 16'h3311, 16'h3311, 2'b11, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h44332211, 4'hF, 16'h0000, 16'h3311, 2'b00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h88776655, 4'hF, 16'h7755, 16'h7755, 2'b11, 1'b1});

        #2;
        chk_all("reset", 16'h0, 16'h0, 2'b00, 1'b0);
        chk("reset d2", d2, 64'h0);
        chk("reset v2", 64'(v2), 64'h0);
        step();
        reset = 1'b0;
        ph_prev = 1'b0;
        foreach (tbl[i]) begin
            enable = tbl[i].en;
            align = tbl[i].al;
            din = tbl[i].din;
            vin = tbl[i].vin;
            step();
            chk_all($sformatf("v%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].v, tbl[i].ph);
            adv = tbl[i].en & ~tbl[i].al;
            chk($sformatf("v%0d d2", i), d2, adv ? (ph_prev ? OD2 : EV2) : 64'h0);
            chk($sformatf("v%0d v2", i), 64'(v2), adv ? 64'hF : 64'h0);
            ph_prev = tbl[i].ph;
        end

        // asynchronous reset in the middle of a pair
        enable = 1'b1;
        align = 1'b0;
        din = 32'h44332211;
        vin = 4'hF;
        step();
        chk_all("pre0", 16'h8866, 16'h8866, 2'b11, 1'b0);
        step();
        chk_all("pre1", 16'h3311, 16'h3311, 2'b11, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("arst", 16'h0, 16'h0, 2'b00, 1'b0);
        chk("arst d2", d2, 64'h0);
        chk("arst v2", 64'(v2), 64'h0);
        step();
        reset = 1'b0;
        din = 32'h88776655;
        step();
        chk_all("post0", 16'h7755, 16'h7755, 2'b11, 1'b1);
        chk("post0 d2", d2, EV2);
        step();
        chk_all("post1", 16'h8866, 16'h8866, 2'b11, 1'b0);
        chk("post1 d2", d2, OD2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_serial_layer.md
# mux_serial_layer

Parametrised 2:1 time-division multiplexing layer for the byte-striping datapath. It takes `2*LANES_OUT` parallel input lanes, each carrying a valid flag, and serialises each adjacent pair onto one output lane over two clock cycles. An internal phase register replaces the externally driven selector of the previous generation, and a synchronous `align` input lets upstream logic re-phase the layer. Layers cascade (output of one feeds input of the next) to build 2^k:1 trees.

## Interface
- `WIDTH`, 8, data bits per lane
- `LANES_OUT`, 2, output lanes; input lanes = `2*LANES_OUT`
- `ZERO_INVALID`, 1, when 1 `data_out` lane is driven to 0 whenever its valid is 0; when 0 the data is passed unmodified
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `enable`  in  1  advance phase and update outputs this cycle
- `align`  in  1  synchronous phase realignment
- `data_in`  in  `2*LANES_OUT*WIDTH`  input lane i at bits `[i*WIDTH +: WIDTH]`
- `valid_in`  in  `2*LANES_OUT`  bit i qualifies input lane i
- `data_out`  out  `LANES_OUT*WIDTH`  output lane j at bits `[j*WIDTH +: WIDTH]`, registered
- `valid_out`  out  `LANES_OUT`  bit j qualifies output lane j, registered
- `phase`  out  1  current phase, registered

## Operation
- Phase register: reset 0. With `enable=1, align=0` it toggles every cycle. With `enable=0` it holds. With `align=1` the next value is 0, regardless of `enable`.
- Phase 0, enabled, no align:
  - Capture all odd input lanes (`2j+1`) and their valids into the hold registers.
  - Output lane j loads input lane `2j` and `valid_in[2j]`.
- Phase 1, enabled, no align: output lane j loads hold lane `2j+1` and its held valid. The live inputs are ignored.
- `enable=0` or `align=1`:
  - `valid_out` goes to 0 on the next edge.
  - `data_out` holds, or is 0 if `ZERO_INVALID=1`.
  - Hold registers are unchanged.
- `ZERO_INVALID=1`: any output lane loaded with valid=0 also loads data 0.
- Inputs must be stable and sampled only on phase-0 enabled cycles. Upstream presents a new pair every 2 enabled cycles.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `phase`=0, hold data and valids=0.
- Even lane (`2j`) latency: 1 cycle (sampled at phase-0 edge, visible after it).
- Odd lane (`2j+1`) latency: 2 enabled cycles; appears in the cycle immediately following its even partner.
- Throughput: one pair per 2 enabled cycles per output lane; output valid every cycle under continuous valid input.
- `enable` low between phase 0 and phase 1: the odd sample stays held and is emitted on the next enabled cycle. No loss.
- `align` during phase 1: the pending odd sample is dropped, `valid_out=0` that cycle, and phase 0 resumes on the following cycle.
- Reset asserted mid-pair: everything clears asynchronously and the pending odd sample is lost. First enabled cycle after deassertion is phase 0.
- `align` and `enable` both high: `align` wins.

## Structure
- Shared package `mux_pkg`:
  - default `WIDTH`/`LANES_OUT` constants
  - `localparam PHASE_EVEN=1'b0, PHASE_ODD=1'b1`
- One sub-module `serial_lane` (one 2:1 pair with its hold register and output register), instantiated `LANES_OUT` times via generate.
- The phase register lives once in the top and is shared by all lanes.

## Test plan
- Reset, then `enable=1` with `data_in` lanes 0..3 = 0x11,0x22,0x33,0x44, all valid -> `data_out` lane0 = 0x11, 0x22, 0x11, 0x22…; lane1 = 0x33, 0x44…; `valid_out`=2'b11 every cycle; `phase` alternates 0,1.
- `valid_in`=4'b1101, `ZERO_INVALID=1`, data as above -> lane0 emits 0x11 valid, then 0x00 with valid 0; lane1 emits 0x33, 0x44 both valid.
- `enable` dropped for 3 cycles right after a phase-0 capture of lane1=0x22 -> `valid_out`=0 for 3 cycles, phase holds 1; on re-enable lane0 emits 0x22 valid.
- `align` pulsed during phase 1 -> that cycle's `valid_out`=0, `phase`=0 next cycle, and the next pair starts cleanly with the even lane.
- Async `reset` asserted mid-cycle while `valid_out`=1 -> outputs and `phase` go to 0 immediately without a clock edge. After release, the first enabled cycle samples a new pair at phase 0.
- `LANES_OUT=4`, `WIDTH=16`: lane i input = 0x1000+i -> output lane j alternates 0x1000+2j / 0x1001+2j.
